// File: rtl/com_frame_loader_pkg.sv
// Shared definitions for the frame loader: FSM state encoding and parameter defaults.
package com_frame_loader_pkg;

   localparam int unsigned DefDepth   = 1024;   // max words per frame
   localparam int unsigned DefAw      = 10;     // buffer address width
   localparam int unsigned DefTimeout = 50000;  // idle clocks tolerated between bytes

   typedef enum logic [2:0] {
      StIdle,
      StHdr,
      StLoad,
      StWait,
      StStart,
      StLead,
      StStream
   } state_e;

endpackage

// File: rtl/com_frame_loader_buf.sv
// Frame buffer: 16-bit x DEPTH RAM, one write port, one registered read port.
// Ports:
//   clk    system clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address (data appears on rdata one clock later)
//   rdata  registered read data
module loader_buf
   import com_frame_loader_pkg::*;
#(
   parameter int unsigned DEPTH = DefDepth,
   parameter int unsigned AW    = DefAw
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [15:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [15:0]   rdata
);

   logic [15:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/com_frame_loader.sv
// Frame loader: parses a length-prefixed byte stream (len_lo, len_hi, 2*len data bytes),
// buffers the little-endian 16-bit words, then replays them as a gap-free burst for the
// host controller once it is idle.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   rx_valid, rx_data byte strobe and byte from the serial receiver
//   host_idle         host controller is waiting for a new load
//   com_data_in       word to host memory (0 outside the burst)
//   data_write_start  one-cycle strobe, two cycles ahead of word 0
//   data_write_done   one-cycle strobe together with the last word
//   busy              any state other than idle
//   frame_err         sticky error, cleared by the next valid header
module com_frame_loader
   import com_frame_loader_pkg::*;
#(
   parameter int unsigned DEPTH   = DefDepth,
   parameter int unsigned AW      = DefAw,
   parameter int unsigned TIMEOUT = DefTimeout
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   input  logic        host_idle,
   output logic [15:0] com_data_in,
   output logic        data_write_start,
   output logic        data_write_done,
   output logic        busy,
   output logic        frame_err
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   state_e        state;
   logic [7:0]    len_lo;
   logic [7:0]    lo_byte;
   logic          phase;      // 1: low byte held, high byte pending
   logic [AW:0]   len;        // one extra bit so a full buffer (len == DEPTH) is representable
   logic [AW:0]   wcnt;
   logic [AW:0]   rcnt;       // index of the word currently on com_data_in
   logic [AW-1:0] rd_addr;
   logic [TW-1:0] idle_cnt;
   logic [15:0]   rd_data;
   logic [15:0]   hdr_len;
   logic          hdr_bad;
   logic          in_rx;
   logic          timeout;
   logic          we;

   assign hdr_len = {rx_data, len_lo};
   assign hdr_bad = (hdr_len == 16'd0) || (32'(hdr_len) > DEPTH);
   assign in_rx   = (state == StHdr) || (state == StLoad);
   // A byte arriving in the expiry cycle wins over the timeout.
   assign timeout = in_rx && !rx_valid && (idle_cnt == TW'(TIMEOUT - 1));
   assign we      = (state == StLoad) && rx_valid && phase;

   assign com_data_in = (state == StStream) ? rd_data : 16'h0000;
   assign busy        = (state != StIdle);

   loader_buf #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_buf (
      .clk   (clk),
      .we    (we),
      .waddr (wcnt[AW-1:0]),
      .wdata ({rx_data, lo_byte}),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= StIdle;
         len_lo           <= '0;
         lo_byte          <= '0;
         phase            <= 1'b0;
         len              <= '0;
         wcnt             <= '0;
         rcnt             <= '0;
         rd_addr          <= '0;
         idle_cnt         <= '0;
         data_write_start <= 1'b0;
         data_write_done  <= 1'b0;
         frame_err        <= 1'b0;
      end else begin
         data_write_start <= 1'b0;
         data_write_done  <= 1'b0;

         if (rx_valid || timeout || !in_rx) begin
            idle_cnt <= '0;
         end else begin
            idle_cnt <= idle_cnt + 1'b1;
         end

         unique case (state)
            StIdle: begin
               if (rx_valid) begin
                  len_lo <= rx_data;
                  state  <= StHdr;
               end
            end
            StHdr: begin
               if (rx_valid) begin
                  if (hdr_bad) begin
                     frame_err <= 1'b1;
                     state     <= StIdle;
                  end else begin
                     frame_err <= 1'b0;
                     len       <= hdr_len[AW:0];
                     wcnt      <= '0;
                     phase     <= 1'b0;
                     state     <= StLoad;
                  end
               end else if (timeout) begin
                  frame_err <= 1'b1;
                  state     <= StIdle;
               end
            end
            StLoad: begin
               if (rx_valid) begin
                  if (!phase) begin
                     lo_byte <= rx_data;
                     phase   <= 1'b1;
                  end else begin
                     phase <= 1'b0;
                     wcnt  <= wcnt + 1'b1;
                     if (wcnt + 1'b1 == len) begin
                        state <= StWait;
                     end
                  end
               end else if (timeout) begin
                  frame_err <= 1'b1;
                  phase     <= 1'b0;
                  state     <= StIdle;
               end
            end
            StWait: begin
               if (host_idle) begin
                  data_write_start <= 1'b1;
                  state            <= StStart;
               end
            end
            StStart: begin
               rd_addr <= '0;
               state   <= StLead;
            end
            StLead: begin
               // Word 0 is read during this cycle; done leads the data by one register.
               rd_addr         <= rd_addr + 1'b1;
               rcnt            <= '0;
               data_write_done <= (len == (AW+1)'(1));
               state           <= StStream;
            end
            StStream: begin
               rd_addr <= rd_addr + 1'b1;
               if (rcnt + 1'b1 == len) begin
                  state <= StIdle;
               end else begin
                  rcnt            <= rcnt + 1'b1;
                  data_write_done <= (rcnt + (AW+1)'(2) == len);
               end
            end
            default: state <= StIdle;
         endcase

         // Bytes outside reception are dropped but flagged; the burst carries on.
         if (rx_valid && !in_rx && (state != StIdle)) begin
            frame_err <= 1'b1;
         end
      end
   end

endmodule

// File: doc/com_frame_loader.md
Name: com_frame_loader

Overview:
- Upstream feeder for the core-array host controller.
- Receives a byte stream from the serial receiver and parses a length-prefixed frame. Assembles 16-bit words and buffers the whole frame.
- Replays the buffered words as a gap-free burst, one word per clock, with the start/done strobes the host controller needs to fill shared memory from address 0.
- The burst is required because the host controller advances the memory address every cycle once loading starts and cannot stall.

Parameters:
- DEPTH, 1024, maximum words per frame; buffer size.
- AW, 10, buffer address width; must satisfy 2^AW >= DEPTH.
- TIMEOUT, 50000, idle clocks allowed between bytes of one frame before the frame is abandoned.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- rx_valid  in  1  one-cycle strobe; rx_data valid.
- rx_data  in  8  received byte.
- host_idle  in  1  high while host controller waits for a new load; the state output equals 2'b11.
- com_data_in  out  16  word to host memory.
- data_write_start  out  1  one-cycle load-start strobe.
- data_write_done  out  1  one-cycle strobe coincident with last word.
- busy  out  1  frame in progress (any state except IDLE).
- frame_err  out  1  sticky error flag; cleared by the next valid header.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE. Buffer contents are don't-care.
- Frame format: len_lo, len_hi, then 2*len data bytes.
  - Words are little-endian: the first byte is bits [7:0].
  - len is a 16-bit word count.
- IDLE: rx_valid loads len_lo -> HDR.
- HDR: rx_valid forms len.
  - If len==0 or len>DEPTH: set frame_err, return to IDLE.
  - Otherwise: clear frame_err, clear wcnt, go to LOAD.
- LOAD: bytes alternate low/high via a phase bit.
  - On each high byte, write the word to buffer[wcnt] and increment wcnt.
  - When wcnt reaches len -> WAIT.
- Timeout: an idle counter resets on every rx_valid.
  - In HDR or LOAD, if it reaches TIMEOUT: set frame_err, discard partial data, go to IDLE.
- WAIT: when host_idle==1 -> START.
- START: data_write_start=1 for exactly this cycle (cycle S). Preload buffer read address 0 -> LEAD.
- LEAD: cycle S+1. The host presents its pre-increment address; com_data_in is don't-care but driven 0 -> STREAM.
- STREAM: word i is on com_data_in in cycle S+2+i, for i = 0..len-1.
  - Buffer read is synchronous, so the address is issued one cycle ahead.
  - data_write_done=1 only in cycle S+1+len, together with word len-1.
  - Then -> IDLE, with com_data_in returning to 0.
- rx_valid outside IDLE/HDR/LOAD: byte ignored; frame_err set; current burst unaffected.
- Simultaneous timeout expiry and rx_valid: the byte wins and the counter resets.
- Final odd byte: if a timeout occurs with phase==high-pending, it is an error as above.
- len==DEPTH: the buffer fills exactly, with no wrap. wcnt is AW+1 bits wide so that it can equal DEPTH.
- Reset mid-burst: outputs go to 0 immediately; no done strobe is issued.
- data_write_start and data_write_done are never high in the same cycle, since len>=1 places done at S+2 or later.

Decomposition:
- The shared definitions header gains:
  - FSM state encodings (IDLE, HDR, LOAD, WAIT, START, LEAD, STREAM);
  - DEPTH/AW defaults;
  - the TIMEOUT default.
- One sub-module, loader_buf: a single-port-write / registered-read 16-bit x DEPTH RAM with write enable, write address, read address and registered data out. The FSM, assembler and counters stay in the top.

Test Plan:
- Bytes 03 00 11 22 33 44 55 66, host_idle=1 -> start at S; 2211 at S+2, 4433 at S+3, 6655 at S+4; done high only at S+4; frame_err=0.
- Header 00 04 (len=1024) plus 2048 bytes, word k = k -> burst of 1024 words 0..1023 with no gaps; done with word 1023.
- Header 00 00 -> frame_err=1, busy=0, no start. A following valid 1-word frame clears frame_err and streams.
- Header 02 00, then byte AA, then silence for TIMEOUT clocks -> frame_err=1, IDLE; a new frame loads correctly.
- Complete frame with host_idle=0 for 100 cycles -> stays in WAIT; start is issued the cycle after host_idle rises. Extra rx bytes sent meanwhile set frame_err and do not corrupt the burst.
- Assert rst at S+3 of a 5-word burst -> all outputs 0 next edge, no done; a subsequent frame streams normally.
